// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Pipeline stall/flush controller for a 5-stage RV32I pipeline. Decides, each
// cycle, which pipeline registers hold, which receive a bubble, and when the PC
// is reloaded. A redirect that arrives while an I-cache fetch is outstanding is
// deferred (DRAIN state) until the fetch completes, so the fetch address seen by
// the I-cache stays stable.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   rs1/rs2_id_IfId, uses_*  decode-stage source operands
//   rd_id_IdEx, read_mem_IdEx, write_reg_IdEx   execute-stage destination info
//   redirect_Ex, redirect_tgt_Ex                resolved control transfer
//   imem_read, imem_resp     I-cache request outstanding / response valid
//   dmem_req_ExMem, dmem_resp D-cache request in flight / response valid
//   stall_*                  per-register hold strobes
//   flush_IfId, flush_IdEx   bubble-insert strobes
//   pc_load, pc_target       PC reload strobe and value
//
// Optional feature: define HAZARD_PERF_CNT_EN to add four saturating
// performance counters (perf_dwait_cycles, perf_iwait_cycles,
// perf_lu_bubbles, perf_redirects), each PERF_W bits wide.

module hazard_control_unit #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs1_id_IfId,
    input  logic [4:0]        rs2_id_IfId,
    input  logic              uses_rs1_IfId,
    input  logic              uses_rs2_IfId,
    input  logic [4:0]        rd_id_IdEx,
    input  logic              read_mem_IdEx,
    input  logic              write_reg_IdEx,
    input  logic              redirect_Ex,
    input  logic [31:0]       redirect_tgt_Ex,
    input  logic              imem_read,
    input  logic              imem_resp,
    input  logic              dmem_req_ExMem,
    input  logic              dmem_resp,
    output logic              stall_pc,
    output logic              stall_IfId,
    output logic              stall_IdEx,
    output logic              stall_ExMem,
    output logic              stall_MemWb,
    output logic              flush_IfId,
    output logic              flush_IdEx,
    output logic              pc_load,
`ifdef HAZARD_PERF_CNT_EN
    output logic [PERF_W-1:0] perf_dwait_cycles,
    output logic [PERF_W-1:0] perf_iwait_cycles,
    output logic [PERF_W-1:0] perf_lu_bubbles,
    output logic [PERF_W-1:0] perf_redirects,
`endif
    output logic [31:0]       pc_target
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] target_reg, target_next;
    // I-cache response that arrived while the D-side held the pipeline.
    logic        resp_seen_reg, resp_seen_next;

    logic dwait;
    logic iwait;
    logic load_use;

    // Which condition won arbitration this cycle (used by the perf counters).
    logic win_dwait, win_iwait, win_lu, win_redirect;

    assign dwait = dmem_req_ExMem & ~dmem_resp;
    assign iwait = imem_read & ~imem_resp;

    assign load_use = read_mem_IdEx & write_reg_IdEx & (rd_id_IdEx != 5'd0) &
                      ((uses_rs1_IfId & (rs1_id_IfId == rd_id_IdEx)) |
                       (uses_rs2_IfId & (rs2_id_IfId == rd_id_IdEx)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= RUN;
            target_reg    <= 32'd0;
            resp_seen_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            target_reg    <= target_next;
            resp_seen_reg <= resp_seen_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        target_next    = target_reg;
        resp_seen_next = resp_seen_reg;
        stall_pc       = 1'b0;
        stall_IfId     = 1'b0;
        stall_IdEx     = 1'b0;
        stall_ExMem    = 1'b0;
        stall_MemWb    = 1'b0;
        flush_IfId     = 1'b0;
        flush_IdEx     = 1'b0;
        pc_load        = 1'b0;
        pc_target      = 32'd0;
        win_dwait      = 1'b0;
        win_iwait      = 1'b0;
        win_lu         = 1'b0;
        win_redirect   = 1'b0;

        if (!rst) begin
            // Reset holds bubbles in the front of the pipe.
            flush_IfId = 1'b1;
            flush_IdEx = 1'b1;
        end else begin
            unique case (state_reg)
                RUN: begin
                    resp_seen_next = 1'b0;
                    if (dwait) begin
                        // Redirect (if any) stays in EX and is re-presented later.
                        win_dwait   = 1'b1;
                        stall_pc    = 1'b1;
                        stall_IfId  = 1'b1;
                        stall_IdEx  = 1'b1;
                        stall_ExMem = 1'b1;
                        stall_MemWb = 1'b1;
                    end else if (redirect_Ex) begin
                        win_redirect = 1'b1;
                        if (iwait) begin
                            // Fetch address must stay stable until the I-cache answers.
                            state_next  = DRAIN;
                            target_next = redirect_tgt_Ex;
                            stall_pc    = 1'b1;
                            flush_IdEx  = 1'b1;
                        end else begin
                            pc_load    = 1'b1;
                            pc_target  = redirect_tgt_Ex;
                            flush_IfId = 1'b1;
                            flush_IdEx = 1'b1;
                        end
                    end else if (load_use) begin
                        win_lu     = 1'b1;
                        stall_pc   = 1'b1;
                        stall_IfId = 1'b1;
                        flush_IdEx = 1'b1;
                    end else if (iwait) begin
                        win_iwait  = 1'b1;
                        stall_pc   = 1'b1;
                        flush_IfId = 1'b1;
                    end
                end
                DRAIN: begin
                    // The outstanding fetch belongs to the wrong path; discard it.
                    stall_pc   = 1'b1;
                    flush_IfId = 1'b1;
                    if (dwait) begin
                        win_dwait   = 1'b1;
                        stall_IfId  = 1'b1;
                        stall_IdEx  = 1'b1;
                        stall_ExMem = 1'b1;
                        stall_MemWb = 1'b1;
                        if (imem_resp) begin
                            resp_seen_next = 1'b1;
                        end
                    end else if (imem_resp || resp_seen_reg) begin
                        pc_load        = 1'b1;
                        pc_target      = target_reg;
                        state_next     = RUN;
                        resp_seen_next = 1'b0;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] perf_cnt_reg [4];
    logic [3:0]        perf_inc;

    assign perf_inc = {win_redirect, win_lu, win_iwait, win_dwait};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_perf
            always_ff @(posedge clk) begin
                if (!rst) begin
                    perf_cnt_reg[gi] <= '0;
                end else if (perf_inc[gi] && (perf_cnt_reg[gi] != {PERF_W{1'b1}})) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign perf_dwait_cycles = perf_cnt_reg[0];
    assign perf_iwait_cycles = perf_cnt_reg[1];
    assign perf_lu_bubbles   = perf_cnt_reg[2];
    assign perf_redirects    = perf_cnt_reg[3];
`endif

endmodule
